wb_port_seq: RTL and testbench

- Writeback port sequencer between the MEM/WB stage and a single-write-port register file.
- Accepts one writeback record per handshake, carrying an E destination and an M destination.
- Serializes dual writes (POPL writes both %esp and rA) over two cycles and back-pressures the pipeline while it does so.
- Publishes a pending-write mask for hazard logic and a retired-record counter.

---
 rtl/wb_port_seq.sv | 111 +++++++++++
 tb/tb_wb_port_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_seq.sv
// rtl/wb_port_seq.sv - writeback port sequencer feeding a single-write-port register file
// Serializes dual-destination writeback records (E then M) and publishes pending-write state.

module wb_port_seq #(
  parameter int                WORD_W = 32,
  parameter int                REG_W  = 4,
  parameter logic [REG_W-1:0]  RNONE  = 4'hf
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_W-1:0]  wb_dstE,
  input  logic [WORD_W-1:0] wb_valE,
  input  logic [REG_W-1:0]  wb_dstM,
  input  logic [WORD_W-1:0] wb_valM,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [WORD_W-1:0] rf_wdata,
  output logic [15:0]       busy_mask,
  output logic [31:0]       retire_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    WR_E,
    WR_LAST
  } state_t;

  state_t              r_state;
  logic                r_ready;
  logic                r_we;
  logic [REG_W-1:0]    r_waddr;
  logic [WORD_W-1:0]   r_wdata;
  logic [REG_W-1:0]    r_pend_addr;
  logic [WORD_W-1:0]   r_pend_data;
  logic [15:0]         r_busy;
  logic [31:0]         r_retire_cnt;

  logic w_accept;
  logic w_need_e;
  logic w_need_m;
  logic w_same;
  logic w_two;
  logic w_one;

  assign w_accept = wb_valid & r_ready;
  assign w_need_e = (wb_dstE != RNONE);
  assign w_need_m = (wb_dstM != RNONE);
  // popl %esp: both destinations name the same register, the loaded value wins
  assign w_same   = w_need_e & w_need_m & (wb_dstE == wb_dstM);
  assign w_two    = w_need_e & w_need_m & ~w_same;
  assign w_one    = (w_need_e | w_need_m) & ~w_two;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= RNONE;
      r_wdata      <= '0;
      r_pend_addr  <= RNONE;
      r_pend_data  <= '0;
      r_busy       <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end

      if (w_accept && w_two) begin
        r_state     <= WR_E;
        r_we        <= 1'b1;
        r_waddr     <= wb_dstE;
        r_wdata     <= wb_valE;
        r_pend_addr <= wb_dstM;
        r_pend_data <= wb_valM;
        r_busy      <= 16'd1 << wb_dstM;
        r_ready     <= 1'b0;
      end else if (w_accept && w_one) begin
        r_state <= WR_LAST;
        r_we    <= 1'b1;
        r_waddr <= w_need_m ? wb_dstM : wb_dstE;
        r_wdata <= w_need_m ? wb_valM : wb_valE;
        r_busy  <= '0;
        r_ready <= 1'b1;
      end else if (r_state == WR_E) begin
        r_state <= WR_LAST;
        r_we    <= 1'b1;
        r_waddr <= r_pend_addr;
        r_wdata <= r_pend_data;
        r_busy  <= '0;
        r_ready <= 1'b1;
      end else begin
        // no write this cycle; address/data hold their last values
        r_state <= IDLE;
        r_we    <= 1'b0;
        r_busy  <= '0;
        r_ready <= 1'b1;
      end
    end
  end

  assign wb_ready   = r_ready;
  assign rf_we      = r_we;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign busy_mask  = r_busy;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_port_seq.sv
// tb/tb_wb_port_seq.sv - randomized and directed bench for wb_port_seq against a queue-based model

module tb_wb_port_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_ready;
  logic [3:0]  wb_dstE = 4'hf;
  logic [31:0] wb_valE = '0;
  logic [3:0]  wb_dstM = 4'hf;
  logic [31:0] wb_valM = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] busy_mask;
  logic [31:0] retire_cnt;

  wb_port_seq dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_dstE    (wb_dstE),
    .wb_valE    (wb_valE),
    .wb_dstM    (wb_dstM),
    .wb_valM    (wb_valM),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy_mask  (busy_mask),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: every accepted record becomes a list of register writes, one per cycle.
  typedef struct packed {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         q[$];
  logic        m_we    = 1'b0;
  logic [3:0]  m_addr  = 4'hf;
  logic [31:0] m_data  = '0;
  logic [15:0] m_busy  = '0;
  logic        m_ready = 1'b0;
  logic [31:0] m_cnt   = '0;
  logic [31:0] cnt_bias = '0;
  logic        chk_en  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_we    = 1'b0;
      m_addr  = 4'hf;
      m_data  = '0;
      m_busy  = '0;
      m_ready = 1'b0;
      m_cnt   = '0;
    end else begin
      if (wb_valid && m_ready) begin
        m_cnt = m_cnt + 32'd1;
        if (wb_dstE != 4'hf && !(wb_dstM != 4'hf && wb_dstE == wb_dstM))
          q.push_back('{a: wb_dstE, d: wb_valE});
        if (wb_dstM != 4'hf)
          q.push_back('{a: wb_dstM, d: wb_valM});
      end
      if (q.size() > 0) begin
        m_we   = 1'b1;
        m_addr = q[0].a;
        m_data = q[0].d;
        void'(q.pop_front());
      end else begin
        m_we = 1'b0;
      end
      m_ready = (q.size() == 0);
      m_busy  = (q.size() > 0) ? (16'd1 << q[0].a) : 16'd0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_we",      32'(rf_we),     32'(m_we));
      chk("rf_waddr",   32'(rf_waddr),  32'(m_addr));
      chk("rf_wdata",   rf_wdata,       m_data);
      chk("wb_ready",   32'(wb_ready),  32'(m_ready));
      chk("busy_mask",  32'(busy_mask), 32'(m_busy));
      chk("retire_cnt", retire_cnt,     m_cnt + cnt_bias);
    end
  end

  task automatic offer(input logic [3:0] de, input logic [31:0] ve,
                       input logic [3:0] dm, input logic [31:0] vm);
    wb_valid = 1'b1;
    wb_dstE  = de;
    wb_valE  = ve;
    wb_dstM  = dm;
    wb_valM  = vm;
  endtask

  function automatic logic [3:0] rand_dst();
    logic [3:0] r;
    if ($urandom_range(0, 3) == 0) r = 4'hf;
    else r = 4'($urandom_range(0, 14));
    return r;
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("reset rf_we",      32'(rf_we),     32'd0);
    chk("reset rf_waddr",   32'(rf_waddr),  32'hf);
    chk("reset rf_wdata",   rf_wdata,       32'd0);
    chk("reset wb_ready",   32'(wb_ready),  32'd0);
    chk("reset busy_mask",  32'(busy_mask), 32'd0);
    chk("reset retire_cnt", retire_cnt,     32'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("ready after reset", 32'(wb_ready), 32'd1);

    // IRMOVL-style single E write
    offer(4'd3, 32'h1234_5678, 4'hf, 32'd0);
    @(negedge clk);
    chk("irmovl we",    32'(rf_we),    32'd1);
    chk("irmovl waddr", 32'(rf_waddr), 32'd3);
    chk("irmovl wdata", rf_wdata,      32'h1234_5678);
    wb_valid = 1'b0;
    @(negedge clk);
    chk("irmovl idle we", 32'(rf_we),   32'd0);
    chk("irmovl cnt",     retire_cnt,   32'd1);

    // POPL with a second record held behind it
    offer(4'd4, 32'h100, 4'd2, 32'hABCD);
    @(negedge clk);
    chk("popl c1 waddr", 32'(rf_waddr),  32'd4);
    chk("popl c1 wdata", rf_wdata,       32'h100);
    chk("popl c1 ready", 32'(wb_ready),  32'd0);
    chk("popl c1 busy",  32'(busy_mask), 32'h4);
    offer(4'd1, 32'd7, 4'hf, 32'd0);
    @(negedge clk);
    chk("popl c2 waddr", 32'(rf_waddr),  32'd2);
    chk("popl c2 wdata", rf_wdata,       32'hABCD);
    chk("popl c2 ready", 32'(wb_ready),  32'd1);
    chk("popl c2 busy",  32'(busy_mask), 32'h0);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("popl c3 waddr", 32'(rf_waddr), 32'd1);
    chk("popl c3 wdata", rf_wdata,      32'd7);
    chk("popl c3 cnt",   retire_cnt,    32'd3);

    // popl %esp: M wins, single cycle
    offer(4'd4, 32'h104, 4'd4, 32'h55);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("esp we",    32'(rf_we),    32'd1);
    chk("esp waddr", 32'(rf_waddr), 32'd4);
    chk("esp wdata", rf_wdata,      32'h55);
    chk("esp ready", 32'(wb_ready), 32'd1);
    @(negedge clk);
    chk("esp no second write", 32'(rf_we), 32'd0);

    // no destinations: retired without a write
    offer(4'hf, 32'hDEAD, 4'hf, 32'hBEEF);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("none we",  32'(rf_we),  32'd0);
    chk("none cnt", retire_cnt,  32'd5);

    // randomized traffic; upstream holds a record while it is not accepted
    for (int i = 0; i < 500; i++) begin
      if (!(wb_valid && !wb_ready)) begin
        wb_valid = ($urandom_range(0, 3) != 0);
        wb_dstE  = rand_dst();
        wb_dstM  = ($urandom_range(0, 5) == 0) ? wb_dstE : rand_dst();
        wb_valE  = $urandom;
        wb_valM  = $urandom;
      end
      @(negedge clk);
    end
    wb_valid = 1'b0;
    @(negedge clk);

    // asynchronous reset in the middle of a dual write
    offer(4'd4, 32'h200, 4'd6, 32'h66);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("mid-reset pre we",   32'(rf_we),     32'd1);
    chk("mid-reset pre busy", 32'(busy_mask), 32'h40);
    #2 rst = 1'b0;
    #1;
    chk("mid-reset we",    32'(rf_we),     32'd0);
    chk("mid-reset busy",  32'(busy_mask), 32'd0);
    chk("mid-reset cnt",   retire_cnt,     32'd0);
    chk("mid-reset ready", 32'(wb_ready),  32'd0);
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    chk("post-reset no M write", 32'(rf_we), 32'd0);
    @(negedge clk);
    chk("post-reset idle", 32'(rf_we), 32'd0);

    // retire counter wrap
    chk_en = 1'b0;
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    cnt_bias = 32'hFFFF_FFFF - m_cnt;
    #1 release dut.r_retire_cnt;
    chk_en = 1'b1;
    @(negedge clk);
    chk("preload cnt", retire_cnt, 32'hFFFF_FFFF);
    offer(4'd5, 32'h5, 4'hf, 32'd0);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("wrap cnt", retire_cnt, 32'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
